i281_cpu_mc: RTL and testbench
==============================

I281_CPU_MC -- requirements
Module: i281_cpu_mc

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 8, register/ALU/data-memory word width (>=8).
REQ-002 Parameters SHALL also include: PC_W, 6, code-address width; DADDR_W, 4, data-address width.
REQ-003 Ports SHALL be (name direction width meaning): clock in 1 sole clock, rising edge; reset in 1 asynchronous active-low reset.
REQ-004 Port: run in 1, level enable; instruction issue is allowed while high.
REQ-005 Ports: switches in DATA_W, INPUT source; halted out 1, HALT executed.
REQ-006 Ports: imem_req out 1; imem_addr out PC_W; imem_rdata in 16; imem_ack in 1.
REQ-007 Ports: dmem_req out 1; dmem_we out 1; dmem_addr out DADDR_W; dmem_wdata out DATA_W; dmem_rdata in DATA_W; dmem_ack in 1.
REQ-008 Ports: pc out PC_W, current PC; flags out 4, {C,O,N,Z}.

Function
REQ-009 Instruction format SHALL be op=[15:12], rx=[11:10], ry=[9:8], imm=[7:0]; four registers R0..R3 of DATA_W bits.
REQ-010 Opcodes SHALL be 0 NOOP, 1 LOADI rx<=imm, 2 ADD rx<=rx+ry, 3 ADDI rx<=rx+imm, 4 SUB rx<=rx-ry, 5 SUBI rx<=rx-imm, 6 LOAD rx<=dmem[imm], 7 STORE dmem[imm]<=rx.
REQ-011 Opcodes SHALL continue 8 CMP (rx-ry, flags only), 9 JUMP, 10 BRE (Z), 11 BRNE (!Z), 12 BRG (!Z & N==O), 13 BRGE (N==O), 14 INPUT rx<=switches, 15 HALT.
REQ-012 imm SHALL be sign-extended to DATA_W for arithmetic and LOADI; truncated to DADDR_W for addresses.
REQ-013 ADD/ADDI/SUB/SUBI/CMP SHALL update all four flags; other opcodes SHALL leave flags unchanged; C = carry-out (SUB: no borrow), O = signed overflow, N = MSB, Z = result zero.
REQ-014 Taken JUMP/branch SHALL set pc <= pc+1+sext(imm) modulo 2^PC_W; otherwise pc <= pc+1 modulo 2^PC_W (wraps from all-ones to 0).
REQ-015 FSM states SHALL be IDLE, FETCH, EXEC, MEM, HALT.
REQ-016 IDLE->FETCH when run=1; FETCH holds imem_req=1, imem_addr=pc until a cycle with imem_ack=1, latches imem_rdata, then ->EXEC.
REQ-017 EXEC SHALL take one cycle: commits register, flag and pc updates; LOAD/STORE ->MEM; HALT ->HALT; else ->FETCH if run=1, ->IDLE if run=0.
REQ-018 MEM SHALL hold dmem_req=1 with stable addr/we/wdata until dmem_ack=1; LOAD writes rx from dmem_rdata that cycle, pc advances, then next state as in REQ-017.
REQ-019 Minimum latency: ALU instruction 2 cycles with zero-wait ack; LOAD/STORE 3 cycles.
REQ-020 run falling mid-instruction SHALL NOT abort it; stop occurs only at instruction boundary.
REQ-021 req SHALL deassert the cycle after ack; ack with req low SHALL be ignored.
REQ-022 HALT state SHALL assert halted=1, issue no requests, and leave it only via reset.
REQ-023 Writes to R0..R3 from two sources in one cycle SHALL NOT occur (single write port, one commit per instruction).

Reset
REQ-024 reset=0 SHALL asynchronously force state IDLE, pc=0, R0..R3=0, flags=0, halted=0, imem_req=0, dmem_req=0, dmem_we=0, aborting any pending transfer.
REQ-025 Outstanding acks arriving after reset release SHALL be ignored (state IDLE, no req).

Configuration
REQ-026 Macro I281_STEP_EN defined: input step (1 bit) added; with run=0, a rising edge of step (edge-detected internally, registered) SHALL execute exactly one instruction from IDLE and return to IDLE.
REQ-027 I281_STEP_EN undefined: no step port; only run controls issue.

Verification
REQ-028 Reset, run=1, imem: LOADI R1,5; ADDI R1,-1; HALT, ack every cycle -> R1=4, flags Z=0 N=0, halted=1 on cycle 7, pc=2.
REQ-029 DATA_W=8: LOADI R0,0x7F; ADDI R0,1 -> R0=0x80, O=1, N=1, C=0, Z=0.
REQ-030 STORE R2 to addr 3 with dmem_ack delayed 4 cycles -> dmem_req high 5 cycles, addr=3, we=1, wdata constant; pc unchanged until ack.
REQ-031 CMP R0,R1 with R0=R1, then BRE +2 at pc=10 -> next fetch addr 13; PC_W=6, pc=63 NOOP -> next fetch addr 0.
REQ-032 Assert reset=0 during FETCH wait -> imem_req drops same cycle, pc=0; late ack after release ignored.
REQ-033 With I281_STEP_EN, run=0, three step pulses -> exactly three instructions retired, IDLE between each.

Source files
------------

// File: rtl/i281_cpu_mc.sv
// +--------------------------------------------------------------------------+
// | i281_cpu_mc: multi-cycle i281 CPU, handshake instruction/data memories.  |
// | Optional I281_STEP_EN adds a single-step input.  Revision 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module i281_cpu_mc #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 6,
  parameter int DADDR_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
`ifdef I281_STEP_EN
  input  logic               step,
`endif
  input  logic [DATA_W-1:0]  switches,
  output logic               halted,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         flags
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] OP_LOADI = 4'd1,  OP_ADD  = 4'd2,  OP_ADDI = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4,  OP_SUBI = 4'd5,  OP_LOAD = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7,  OP_CMP  = 4'd8,  OP_JUMP = 4'd9;
  localparam logic [3:0] OP_BRE   = 4'd10, OP_BRNE = 4'd11, OP_BRG  = 4'd12;
  localparam logic [3:0] OP_BRGE  = 4'd13, OP_INPUT = 4'd14, OP_HALT = 4'd15;

  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [3:0]        r_flags;
  logic              r_halted;
  logic [DATA_W-1:0] r_regs [4];

  logic [3:0]        w_op;
  logic [1:0]        w_rx, w_ry;
  logic [7:0]        w_imm8;
  logic [DATA_W-1:0] w_imm_d, w_a, w_b, w_bx, w_res, w_rf_data;
  logic [DATA_W:0]   w_sum;
  logic              w_sub, w_ovf, w_is_alu, w_taken, w_rf_we, w_start;
  logic [3:0]        w_alu_flags;
  logic [PC_W-1:0]   w_pc_inc, w_pc_br;

`ifdef I281_STEP_EN
  logic r_step_q, r_step_qq;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step_q  <= 1'b0;
      r_step_qq <= 1'b0;
    end else begin
      r_step_q  <= step;
      r_step_qq <= r_step_q;
    end
  end
  assign w_start = run | (r_step_q & ~r_step_qq);
`else
  assign w_start = run;
`endif

  assign w_op    = r_ir[15:12];
  assign w_rx    = r_ir[11:10];
  assign w_ry    = r_ir[9:8];
  assign w_imm8  = r_ir[7:0];
  assign w_imm_d = DATA_W'($signed(w_imm8));
  assign w_a     = r_regs[w_rx];
  assign w_b     = (w_op == OP_ADDI || w_op == OP_SUBI) ? w_imm_d : r_regs[w_ry];
  assign w_sub   = (w_op == OP_SUB) || (w_op == OP_SUBI) || (w_op == OP_CMP);
  assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_ADDI) || w_sub;

  // Subtraction is a + ~b + 1, so carry-out means "no borrow".
  assign w_bx  = w_sub ? ~w_b : w_b;
  assign w_sum = {1'b0, w_a} + {1'b0, w_bx} + {{DATA_W{1'b0}}, w_sub};
  assign w_res = w_sum[DATA_W-1:0];
  assign w_ovf = (w_a[DATA_W-1] ^ w_bx[DATA_W-1] ^ 1'b1) & (w_res[DATA_W-1] ^ w_a[DATA_W-1]);
  assign w_alu_flags = {w_sum[DATA_W], w_ovf, w_res[DATA_W-1], (w_res == '0)};

  assign w_pc_inc = r_pc + 1'b1;
  assign w_pc_br  = w_pc_inc + PC_W'($signed(w_imm8));

  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_JUMP: w_taken = 1'b1;
      OP_BRE:  w_taken = r_flags[0];
      OP_BRNE: w_taken = ~r_flags[0];
      OP_BRG:  w_taken = ~r_flags[0] & (r_flags[1] == r_flags[2]);
      OP_BRGE: w_taken = (r_flags[1] == r_flags[2]);
      default: w_taken = 1'b0;
    endcase
  end

  // Single register-file write port shared by EXEC results and LOAD data.
  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_data = w_res;
    if (r_state == S_EXEC) begin
      case (w_op)
        OP_LOADI: begin w_rf_we = 1'b1; w_rf_data = w_imm_d; end
        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: w_rf_we = 1'b1;
        OP_INPUT: begin w_rf_we = 1'b1; w_rf_data = switches; end
        default:  w_rf_we = 1'b0;
      endcase
    end else if (r_state == S_MEM && dmem_ack && w_op == OP_LOAD) begin
      w_rf_we   = 1'b1;
      w_rf_data = dmem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      r_regs[w_rx] <= w_rf_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_flags  <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_alu) r_flags <= w_alu_flags;
          if (w_op == OP_LOAD || w_op == OP_STORE) begin
            r_state <= S_MEM;
          end else if (w_op == OP_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= w_taken ? w_pc_br : w_pc_inc;
            r_state <= run ? S_FETCH : S_IDLE;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_pc    <= w_pc_inc;
            r_state <= run ? S_FETCH : S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign halted     = r_halted;
  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = (r_state == S_MEM) && (w_op == OP_STORE);
  assign dmem_addr  = DADDR_W'(w_imm8);
  assign dmem_wdata = w_a;
  assign pc         = r_pc;
  assign flags      = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_i281_cpu_mc.sv
// Directed bench for i281_cpu_mc: vector table of small programs plus
// hand sequences for wait states, branching, PC wrap, reset and stepping.
`default_nettype none

module tb_i281_cpu_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  switches = 8'h00;
  logic        halted, imem_req, dmem_req, dmem_we;
  logic [5:0]  imem_addr, pc;
  logic [15:0] irdata = 16'h0;
  logic        iack = 1'b0, inj_iack = 1'b0, dack = 1'b0;
  logic        imem_ack;
  logic [3:0]  dmem_addr, flags;
  logic [7:0]  dmem_wdata, drdata = 8'h00;

  assign imem_ack = iack | inj_iack;

  i281_cpu_mc #(.DATA_W(8), .PC_W(6), .DADDR_W(4)) dut (
    .clock(clock), .reset(reset), .run(run),
`ifdef I281_STEP_EN
    .step(step),
`endif
    .switches(switches), .halted(halted),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(irdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(drdata), .dmem_ack(dack), .pc(pc), .flags(flags)
  );

  always #5 clock = ~clock;

  logic [15:0] rom [64];
  logic [7:0]  dmem [16];
  int          idelay = 0, ddelay = 0, icnt = 0, dcnt = 0;
  logic [5:0]  fetch_log [$];
  int          dreq_cycles = 0;
  logic [3:0]  d_addr0;
  logic [7:0]  d_wd0;
  logic [5:0]  d_pc0;
  logic        d_unstable = 1'b0;
  int          n_chk = 0, n_fail = 0;

  // Memory responders: react at the falling edge so the CPU sees ack at the next rising edge.
  always @(negedge clock) begin
    if (imem_req) begin
      if (icnt >= idelay) begin
        iack = 1'b1; irdata = rom[imem_addr]; fetch_log.push_back(imem_addr); icnt = 0;
      end else begin
        iack = 1'b0; icnt++;
      end
    end else begin
      iack = 1'b0; icnt = 0;
    end
    if (dmem_req) begin
      if (dreq_cycles == 0) begin
        d_addr0 = dmem_addr; d_wd0 = dmem_wdata; d_pc0 = pc;
      end else if (dmem_addr != d_addr0 || dmem_wdata != d_wd0 || pc != d_pc0) begin
        d_unstable = 1'b1;
      end
      dreq_cycles++;
      if (dcnt >= ddelay) begin
        dack = 1'b1; drdata = dmem[dmem_addr];
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        dcnt = 0;
      end else begin
        dack = 1'b0; dcnt++;
      end
    end else begin
      dack = 1'b0; dcnt = 0;
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rx,
                                      input logic [1:0] ry, input logic [7:0] imm);
    return {op, rx, ry, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; inj_iack = 1'b0; step = 1'b0;
    idelay = 0; ddelay = 0;
    repeat (2) @(negedge clock);
    fetch_log.delete(); dreq_cycles = 0; d_unstable = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    reset = 1'b1;
  endtask

  task automatic wait_halt(input int maxc);
    int n;
    n = 0;
    while (!halted && n < maxc) begin
      @(negedge clock); n++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, imm, exp_r0;
    logic [3:0] exp_fl;
  } vec_t;
  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd3,  8'h7F, 8'h00, 8'h01, 8'h80, 4'b0110}; // ADDI overflow
    vecs[1] = '{4'd2,  8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001}; // ADD carry to zero
    vecs[2] = '{4'd4,  8'h05, 8'h07, 8'h00, 8'hFE, 4'b0010}; // SUB with borrow
    vecs[3] = '{4'd5,  8'h80, 8'h00, 8'h01, 8'h7F, 4'b1100}; // SUBI overflow
    vecs[4] = '{4'd8,  8'h03, 8'h03, 8'h00, 8'h03, 4'b1001}; // CMP equal
    vecs[5] = '{4'd14, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0000}; // INPUT
    vecs[6] = '{4'd2,  8'h80, 8'h80, 8'h00, 8'h00, 4'b1101}; // ADD neg overflow
    vecs[7] = '{4'd6,  8'h00, 8'h00, 8'h05, 8'h3C, 4'b0000}; // LOAD
    vecs[8] = '{4'd3,  8'h10, 8'h00, 8'hF0, 8'h00, 4'b1001}; // ADDI negative imm
    vecs[9] = '{4'd4,  8'h07, 8'h05, 8'h00, 8'h02, 4'b1000}; // SUB no borrow

    // Reset state
    do_reset();
    @(negedge clock);
    check("rst_pc", {26'd0, pc}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_reqs", {30'd0, imem_req, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_r3", {24'd0, dut.r_regs[3]}, 32'd0);

    // Table: LOADI R0,a; LOADI R1,b; <op R0,R1/imm>; HALT
    for (int v = 0; v < 10; v++) begin
      do_reset();
      rom[0] = enc(4'd1, 2'd0, 2'd0, vecs[v].a);
      rom[1] = enc(4'd1, 2'd1, 2'd0, vecs[v].b);
      rom[2] = enc(vecs[v].op, 2'd0, 2'd1, vecs[v].imm);
      rom[3] = enc(4'd15, 2'd0, 2'd0, 8'h00);
      dmem[5] = 8'h3C; switches = 8'hA5;
      run = 1'b1;
      wait_halt(60);
      check($sformatf("vec%0d_r0", v), {24'd0, dut.r_regs[0]}, {24'd0, vecs[v].exp_r0});
      check($sformatf("vec%0d_flags", v), {28'd0, flags}, {28'd0, vecs[v].exp_fl});
      check($sformatf("vec%0d_pc", v), {26'd0, pc}, 32'd3);
    end

    // LOADI R1,5; ADDI R1,-1; HALT with halted on cycle 7
    reset = 1'b0; run = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom[0] = enc(4'd1, 2'd1, 2'd0, 8'd5);
    rom[1] = enc(4'd3, 2'd1, 2'd0, 8'hFF);
    rom[2] = enc(4'd15, 2'd0, 2'd0, 8'h00);
    @(negedge clock); fetch_log.delete();
    reset = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clock); #1;
      if (c == 6) check("halt_c6", {31'd0, halted}, 32'd0);
      if (c == 7) check("halt_c7", {31'd0, halted}, 32'd1);
    end
    check("seq_r1", {24'd0, dut.r_regs[1]}, 32'd4);
    check("seq_flags", {28'd0, flags}, 32'b1000);
    check("seq_pc", {26'd0, pc}, 32'd2);

    // STORE with 4-cycle dmem ack delay
    do_reset();
    ddelay = 4;
    rom[0] = enc(4'd1, 2'd2, 2'd0, 8'h5A);
    rom[1] = enc(4'd7, 2'd2, 2'd0, 8'd3);
    rom[2] = enc(4'd15, 2'd0, 2'd0, 8'h00);
    dmem[3] = 8'h00;
    run = 1'b1;
    wait_halt(60);
    check("st_req_cycles", dreq_cycles, 32'd5);
    check("st_addr", {28'd0, d_addr0}, 32'd3);
    check("st_wdata", {24'd0, d_wd0}, 32'h5A);
    check("st_pc_during", {26'd0, d_pc0}, 32'd1);
    check("st_stable", {31'd0, d_unstable}, 32'd0);
    check("st_mem", {24'd0, dmem[3]}, 32'h5A);
    check("st_pc_end", {26'd0, pc}, 32'd2);

    // CMP equal then BRE +2 at pc 10
    do_reset();
    rom[0] = enc(4'd1, 2'd0, 2'd0, 8'd7);
    rom[1] = enc(4'd1, 2'd1, 2'd0, 8'd7);
    rom[2] = enc(4'd8, 2'd0, 2'd1, 8'd0);
    rom[10] = enc(4'd10, 2'd0, 2'd0, 8'd2);
    rom[13] = enc(4'd15, 2'd0, 2'd0, 8'h00);
    run = 1'b1;
    wait_halt(100);
    check("br_log_len", fetch_log.size(), 32'd12);
    if (fetch_log.size() >= 12) begin
      check("br_from", {26'd0, fetch_log[10]}, 32'd10);
      check("br_target", {26'd0, fetch_log[11]}, 32'd13);
    end
    check("br_flags", {28'd0, flags}, 32'b1001);

    // JUMP -2 from 0 lands on 63; NOOP at 63 wraps to 0; run drop finishes instruction
    do_reset();
    rom[0] = enc(4'd9, 2'd0, 2'd0, 8'hFE);
    run = 1'b1;
    for (int n = 0; n < 50 && fetch_log.size() < 3; n++) @(negedge clock);
    run = 1'b0;
    check("wrap_log_len", {31'd0, fetch_log.size() >= 3}, 32'd1);
    if (fetch_log.size() >= 3) begin
      check("wrap_jump", {26'd0, fetch_log[1]}, 32'd63);
      check("wrap_zero", {26'd0, fetch_log[2]}, 32'd0);
    end
    repeat (4) @(negedge clock);
    check("stop_req", {31'd0, imem_req}, 32'd0);
    check("stop_pc", {26'd0, pc}, 32'd63);

    // Reset during a stalled fetch, then a stray ack
    do_reset();
    run = 1'b1;
    repeat (6) @(negedge clock);
    idelay = 1000;
    for (int n = 0; n < 10 && !imem_req; n++) @(negedge clock);
    repeat (2) @(negedge clock);
    check("fw_req_high", {31'd0, imem_req}, 32'd1);
    check("fw_pc_nonzero", {31'd0, pc != 6'd0}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("fw_req_drop", {31'd0, imem_req}, 32'd0);
    check("fw_pc_zero", {26'd0, pc}, 32'd0);
    run = 1'b0;
    @(negedge clock); reset = 1'b1; idelay = 0;
    @(negedge clock); inj_iack = 1'b1;
    @(negedge clock); inj_iack = 1'b0;
    @(negedge clock);
    check("late_ack_req", {30'd0, imem_req, dmem_req}, 32'd0);
    check("late_ack_pc", {26'd0, pc}, 32'd0);

`ifdef I281_STEP_EN
    // Three step pulses with run low
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1; repeat (2) @(negedge clock);
      step = 1'b0; repeat (8) @(negedge clock);
      check($sformatf("step%0d_pc", k), {26'd0, pc}, k);
      check($sformatf("step%0d_idle", k), {31'd0, imem_req}, 32'd0);
    end
    check("step_fetches", fetch_log.size(), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
